// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// Optional rounding in the top level is selected by the SEQ_DIV_ROUND_EN macro.
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Wide enough for any supported dividend width; the top slices what it needs.
    localparam int MAX_DIVIDEND_W = 64;
    localparam logic [MAX_DIVIDEND_W-1:0] DBZ_QUOTIENT = '1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract, keep or restore.
module div_step #(
    parameter int DIVISOR_W = 3
) (
    input  logic [DIVISOR_W-1:0] i_r,
    input  logic                 i_bit,
    input  logic [DIVISOR_W-1:0] i_divisor,
    output logic [DIVISOR_W-1:0] o_rNext,
    output logic                 o_qBit
);

    logic [DIVISOR_W:0] w_shifted;
    logic [DIVISOR_W:0] w_sub;
    logic               w_borrow;

    // A borrow out of the DIVISOR_W+1 bit subtract means r < divisor, so the old value is restored.
    assign w_shifted         = {i_r, i_bit};
    assign {w_borrow, w_sub} = {1'b0, w_shifted} - {2'b00, i_divisor};
    assign o_qBit            = ~w_borrow;
    assign o_rNext           = w_borrow ? w_shifted[DIVISOR_W-1:0] : DIVISOR_W'(w_sub);

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned divider, one quotient bit per clock, start/done handshake.
// Define SEQ_DIV_ROUND_EN to round the quotient to nearest (half up, saturating).
module seq_restoring_divider
    import seq_div_pkg::*;
#(
    parameter int DIVIDEND_W = 9,
    parameter int DIVISOR_W  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = clog2(DIVIDEND_W + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIVIDEND_W - 1);
    localparam logic [DIVIDEND_W-1:0] ALL_ONES = DBZ_QUOTIENT[DIVIDEND_W-1:0];

    state_t                r_state;
    state_t                w_stateNext;
    logic [CNT_W-1:0]      r_count;
    logic [DIVIDEND_W-1:0] r_dividendSh;
    logic [DIVIDEND_W-2:0] r_quotSh;
    logic [DIVISOR_W-1:0]  r_divisor;
    logic [DIVISOR_W-1:0]  r_rem;
    logic [DIVIDEND_W-1:0] r_quotient;
    logic [DIVISOR_W-1:0]  r_remainder;
    logic                  r_divByZero;

    logic                  w_accept;
    logic                  w_lastStep;
    logic [DIVISOR_W-1:0]  w_rNext;
    logic                  w_qBit;
    logic [DIVIDEND_W-1:0] w_quotRaw;
    logic [DIVIDEND_W-1:0] w_quotFinal;

    div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .i_r       (r_rem),
        .i_bit     (r_dividendSh[DIVIDEND_W-1]),
        .i_divisor (r_divisor),
        .o_rNext   (w_rNext),
        .o_qBit    (w_qBit)
    );

    assign w_accept   = start && (r_state != RUN);
    assign w_lastStep = (r_state == RUN) && (r_count == LAST_STEP);
    assign w_quotRaw  = {r_quotSh, w_qBit};

`ifdef SEQ_DIV_ROUND_EN
    logic w_roundUp;

    // Round half up: 2*r >= divisor, evaluated one bit wider than r so the doubling cannot overflow.
    assign w_roundUp   = {1'b0, w_rNext, 1'b0} >= {2'b00, r_divisor};
    assign w_quotFinal = (w_roundUp && (w_quotRaw != ALL_ONES)) ? w_quotRaw + 1'b1 : w_quotRaw;
`else
    assign w_quotFinal = w_quotRaw;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE, FIN: begin
                if (start) begin
                    w_stateNext = (divisor == '0) ? FIN : RUN;
                end else begin
                    w_stateNext = IDLE;
                end
            end
            RUN: begin
                if (w_lastStep) begin
                    w_stateNext = FIN;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Results land only on FIN entry: at the last iteration, or directly from acceptance for divide by zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count      <= '0;
            r_dividendSh <= '0;
            r_quotSh     <= '0;
            r_divisor    <= '0;
            r_rem        <= '0;
            r_quotient   <= '0;
            r_remainder  <= '0;
            r_divByZero  <= 1'b0;
        end else if (w_accept) begin
            r_count      <= '0;
            r_dividendSh <= dividend;
            r_quotSh     <= '0;
            r_divisor    <= divisor;
            r_rem        <= '0;
            if (divisor == '0) begin
                r_quotient  <= ALL_ONES;
                r_remainder <= '0;
                r_divByZero <= 1'b1;
            end
        end else if (r_state == RUN) begin
            r_count      <= r_count + 1'b1;
            r_dividendSh <= {r_dividendSh[DIVIDEND_W-2:0], 1'b0};
            r_quotSh     <= w_quotRaw[DIVIDEND_W-2:0];
            r_rem        <= w_rNext;
            if (w_lastStep) begin
                r_quotient  <= w_quotFinal;
                r_remainder <= w_rNext;
                r_divByZero <= 1'b0;
            end
        end
    end

    assign busy        = (r_state == RUN);
    assign done        = (r_state == FIN);
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_divByZero;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider against an arithmetic reference model.
// Honours SEQ_DIV_ROUND_EN in the model when the design is built with rounding.
module tb_seq_restoring_divider;

    localparam int DW   = 9;
    localparam int SW   = 3;
    localparam int MAXQ = (1 << DW) - 1;

    logic          clk;
    logic          rst;
    logic          start;
    logic [DW-1:0] dividend;
    logic [SW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [SW-1:0] remainder;
    logic          div_by_zero;

    int checks;
    int errors;

    seq_restoring_divider #(
        .DIVIDEND_W (DW),
        .DIVISOR_W  (SW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Reference: plain integer division, with optional half-up rounding that saturates.
    function automatic void modelDivide(input int a, input int b, output int q, output int r, output int z);
        if (b == 0) begin
            q = MAXQ;
            r = 0;
            z = 1;
        end else begin
            q = a / b;
            r = a % b;
            z = 0;
`ifdef SEQ_DIV_ROUND_EN
            if ((2 * r >= b) && (q < MAXQ)) q = q + 1;
`endif
        end
    endfunction

    // Call at #1 after a rising edge with the DUT in IDLE or FIN; returns in the done cycle.
    task automatic applyStimulus(input int a, input int b, input string tag);
        int  eq, er, ez;
        int  cyc, busyCyc;
        bit  seen;
        modelDivide(a, b, eq, er, ez);
        start    = 1'b1;
        dividend = DW'(a);
        divisor  = SW'(b);
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = DW'($urandom);
        divisor  = SW'($urandom);
        cyc      = 1;
        busyCyc  = 0;
        seen     = 1'b0;
        while (!seen && cyc <= 20) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) busyCyc++;
                @(posedge clk); #1;
                cyc++;
            end
        end
        checkOutput({tag, "/latency"}, cyc, (b == 0) ? 1 : DW + 1);
        checkOutput({tag, "/busyCycles"}, busyCyc, (b == 0) ? 0 : DW);
        checkOutput({tag, "/quotient"}, quotient, eq);
        checkOutput({tag, "/remainder"}, remainder, er);
        checkOutput({tag, "/divByZero"}, div_by_zero, ez);
    endtask

    initial begin
        int doneCount, firstDone, capQ, capR, busyCount;
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        #2;
        checkOutput("reset/busy", busy, 0);
        checkOutput("reset/done", done, 0);
        checkOutput("reset/quotient", quotient, 0);
        checkOutput("reset/remainder", remainder, 0);
        checkOutput("reset/divByZero", div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        applyStimulus(45, 5, "d45_5");
        applyStimulus(100, 7, "d100_7");
        checkOutput("d100_7/const", quotient, 14);
        applyStimulus(511, 7, "d511_7");
        checkOutput("d511_7/const", quotient, 73);
        applyStimulus(37, 0, "d37_0");
        checkOutput("d37_0/const", quotient, 511);
        applyStimulus(8, 2, "d8_2");
        checkOutput("d8_2/dbzCleared", div_by_zero, 0);
        applyStimulus(13, 5, "d13_5");
        applyStimulus(511, 1, "d511_1");
        checkOutput("d511_1/noWrap", quotient, 511);

        // A start pulse during RUN must be ignored.
        start = 1'b1; dividend = 9'd100; divisor = 3'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; dividend = 9'd45; divisor = 3'd5;
        checkOutput("ignore/heldQuotient", quotient, 511);
        @(posedge clk); #1;
        start = 1'b0;
        doneCount = 0; firstDone = 0; capQ = 0; capR = 0;
        for (int c = 4; c <= 30; c++) begin
            if (done) begin
                doneCount++;
                if (firstDone == 0) begin
                    firstDone = c;
                    capQ = quotient;
                    capR = remainder;
                end
            end
            @(posedge clk); #1;
        end
        checkOutput("ignore/doneCount", doneCount, 1);
        checkOutput("ignore/doneCycle", firstDone, DW + 1);
        checkOutput("ignore/quotient", capQ, 14);
        checkOutput("ignore/remainder", capR, 2);

        // Start held through the FIN cycle launches the next operation straight away.
        applyStimulus(45, 5, "fin_first");
        start = 1'b1; dividend = 9'd100; divisor = 3'd7;
        doneCount = 0; firstDone = 0; capQ = 0;
        for (int c = 1; c <= 25; c++) begin
            @(posedge clk); #1;
            if (c == 4) start = 1'b0;
            if (done) begin
                doneCount++;
                if (firstDone == 0) begin
                    firstDone = c;
                    capQ = quotient;
                end
            end
        end
        checkOutput("finStart/doneCount", doneCount, 1);
        checkOutput("finStart/doneSpacing", firstDone, DW + 1);
        checkOutput("finStart/quotient", capQ, 14);

        // Asynchronous reset in the middle of an operation.
        applyStimulus(37, 0, "preReset");
        start = 1'b1; dividend = 9'd45; divisor = 3'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("asyncReset/busy", busy, 0);
        checkOutput("asyncReset/done", done, 0);
        checkOutput("asyncReset/quotient", quotient, 0);
        checkOutput("asyncReset/remainder", remainder, 0);
        checkOutput("asyncReset/divByZero", div_by_zero, 0);
        #2;
        rst = 1'b0;
        doneCount = 0; busyCount = 0;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            if (done) doneCount++;
            if (busy) busyCount++;
        end
        checkOutput("asyncReset/noDone", doneCount, 0);
        checkOutput("asyncReset/noBusy", busyCount, 0);
        applyStimulus(9, 3, "postReset");
        checkOutput("postReset/const", quotient, 3);

        for (int a = 0; a <= MAXQ; a++) begin
            for (int b = 0; b < (1 << SW); b++) begin
                applyStimulus(a, b, "exhaustive");
            end
        end

        for (int n = 0; n < 300; n++) begin
            applyStimulus(int'($urandom_range(MAXQ)), int'($urandom_range((1 << SW) - 1)), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
